note_player: RTL

Consumer end of the song reader's note handshake. Accepts a `new_note` pulse carrying a 6-bit note and a 6-bit duration, holds that note for `duration` beats while advancing a phase accumulator for the sample generator, then returns a single-cycle `note_done` pulse so the reader can fetch the next note. Sits between the song reader and the frequency ROM / sine-sample path.

---
 rtl/note_if.sv | 15 +
 rtl/note_player.sv | 80 ++++++++
 2 files changed

// File: rtl/note_if.sv
// note_if: note handshake between the song reader (master) and the
// note player (slave).
//   new_note : one-cycle load strobe, reader -> player
//   note     : 6-bit note index, 0 means rest
//   duration : 6-bit length in beats
//   note_done: one-cycle completion pulse, player -> reader
interface note_if;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       note_done;

  modport master (output new_note, note, duration, input note_done);
  modport slave  (input new_note, note, duration, output note_done);
endinterface

// File: rtl/note_player.sv
// note_player: holds a note for its duration in beats while advancing a
// phase accumulator for the sine path, then pulses note_done.
//   clk, reset           : clock, synchronous active-high reset
//   play                 : run enable; low freezes beat count and phase
//   beat                 : one-cycle beat tick
//   generate_next_sample : one-cycle sample-rate strobe
//   step_size            : phase increment from the frequency ROM
//   cur_note             : latched note, frequency ROM address
//   phase                : 22-bit phase accumulator
//   playing              : in PLAY with play high
//   rd                   : note handshake with the song reader
module note_player (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        beat,
  input  logic        generate_next_sample,
  input  logic [19:0] step_size,
  output logic [5:0]  cur_note,
  output logic [21:0] phase,
  output logic        playing,
  note_if.slave       rd
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cur_note_q, cur_note_d;
  logic [5:0]  beats_q, beats_d;
  logic [21:0] phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_note_q <= 6'd0;
      beats_q    <= 6'd0;
      phase_q    <= 22'd0;
    end else begin
      state_q    <= state_d;
      cur_note_q <= cur_note_d;
      beats_q    <= beats_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_note_d = cur_note_q;
    beats_d    = beats_q;
    phase_d    = phase_q;
    // A load is honoured in every state; it also preempts a playing note
    // and swallows a coincident beat.
    if (rd.new_note) begin
      cur_note_d = rd.note;
      beats_d    = rd.duration;
      phase_d    = 22'd0;
      state_d    = (rd.duration == 6'd0) ? DONE : PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (play) begin
            if (beat) begin
              beats_d = beats_q - 6'd1;
              if (beats_q == 6'd1) state_d = DONE;
            end
            // Rests keep phase at 0 so the sine output stays quiet.
            if (generate_next_sample && cur_note_q != 6'd0)
              phase_d = phase_q + {2'b00, step_size};
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign cur_note     = cur_note_q;
  assign phase        = phase_q;
  assign playing      = (state_q == PLAY) && play;
  assign rd.note_done = (state_q == DONE);
endmodule
